// File: rtl/encrypt_engine.sv
// encrypt_engine: iterative AES-128/192/256 cipher, one round per clock.
// The 128-bit State register doubles as the ciphertext output. Bit 0 is the
// MSB of byte 0; byte i sits in row i%4, column i/4.

// SubBytes: byte-wise S-box, built from the GF(2^8) inverse (x^254) followed
// by the affine transform, so no lookup table is needed in the source.
module SubBytes (
    input  logic [0:127] din,
    output logic [0:127] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // substitute every byte of the state
    always_comb begin
        dout = '0;
        for (int i = 0; i < 16; i++) dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
endmodule

// ShiftRows: row r rotates left by r columns.
module ShiftRows (
    input  logic [0:127] din,
    output logic [0:127] dout
);
    // out(r,c) = in(r,(c+r)%4)
    always_comb begin
        dout = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                dout[32*c + 8*r +: 8] = din[32*((c + r) % 4) + 8*r +: 8];
    end
endmodule

// MixColumns with bypass for the final round.
module MixColumns (
    input  logic [0:127] din,
    input  logic         bypass,
    output logic [0:127] dout
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // per-column matrix multiply unless bypassed
    always_comb begin
        dout = din;
        if (!bypass)
            for (int c = 0; c < 4; c++) dout[32*c +: 32] = mix_col(din[32*c +: 32]);
    end
endmodule

module encrypt_engine #(
    parameter int ROUND_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] pt,
    input  logic         pt_vld,
    output logic         pt_rdy,
    input  logic [0:127] rkey,
    input  logic         rkey_vld,
    output logic         next_rkey,
    output logic [0:127] ct,
    output logic         ct_vld,
    input  logic [1:0]   klen_sel
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nx;
    logic [ROUND_W-1:0] round, round_nx;
    logic [ROUND_W-1:0] nr, nr_nx, nr_sel;
    logic [0:127]       ct_nx, sb_out, sr_out, mc_out;
    logic               ct_vld_nx, last, klen_ok;

    assign klen_ok = (klen_sel != 2'b11);
    assign last    = (round == nr);
    assign nr_sel  = (klen_sel == 2'b01) ? ROUND_W'(12) :
                     (klen_sel == 2'b10) ? ROUND_W'(14) : ROUND_W'(10);

    SubBytes   u_sb (.din(ct),     .dout(sb_out));
    ShiftRows  u_sr (.din(sb_out), .dout(sr_out));
    MixColumns u_mc (.din(sr_out), .bypass(last), .dout(mc_out));

    // state, round counter, latched round count and State/ct register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            round  <= '0;
            nr     <= ROUND_W'(10);
            ct     <= '0;
            ct_vld <= 1'b0;
        end else begin
            state  <= state_nx;
            round  <= round_nx;
            nr     <= nr_nx;
            ct     <= ct_nx;
            ct_vld <= ct_vld_nx;
        end
    end

    // next-state and handshake outputs; rst masks the combinational strobes
    always_comb begin
        state_nx  = state;
        round_nx  = round;
        nr_nx     = nr;
        ct_nx     = ct;
        ct_vld_nx = ct_vld;
        pt_rdy    = 1'b0;
        next_rkey = 1'b0;
        case (state)
            IDLE: begin
                pt_rdy = rkey_vld & klen_ok & ~rst;
                if (pt_vld & pt_rdy) begin
                    next_rkey = 1'b1;
                    ct_nx     = pt ^ rkey;
                    nr_nx     = nr_sel;
                    round_nx  = ROUND_W'(1);
                    ct_vld_nx = 1'b0;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                next_rkey = rkey_vld & ~rst;
                if (rkey_vld) begin
                    ct_nx = mc_out ^ rkey;
                    if (last) begin
                        round_nx  = '0;
                        ct_vld_nx = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        round_nx = round + ROUND_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_encrypt_engine.sv
// tb_encrypt_engine: directed FIPS-197 vectors plus randomized blocks, checked
// cycle by cycle against a transaction-level AES model and handshake model.
module tb_encrypt_engine;
    logic         clk, rst;
    logic [127:0] pt, rkey, ct;
    logic         pt_vld, pt_rdy, rkey_vld, next_rkey, ct_vld;
    logic [1:0]   klen_sel;

    encrypt_engine #(.ROUND_W(4)) dut (
        .clk(clk), .rst(rst), .pt(pt), .pt_vld(pt_vld), .pt_rdy(pt_rdy),
        .rkey(rkey), .rkey_vld(rkey_vld), .next_rkey(next_rkey),
        .ct(ct), .ct_vld(ct_vld), .klen_sel(klen_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // stimulus controls
    int   stall_pct = 0, gap_pct = 0, dstall_at = -1, dstall_len = 0;
    bit   rst_req = 0, kv_force = 0, klen_ovr_en = 0;
    logic [1:0] klen_ovr = 2'b00;

    // supplier / source queues and expected results
    logic [127:0] kq[$], ptq[$], ctq[$];
    int           nrq[$];
    logic [1:0]   klq[$];

    // handshake model
    bit           known = 0, running = 0, exp_vld = 0;
    int           keys_left = 0, since_start = 0;
    logic [127:0] exp_ct = '0, run_ct = '0;

    logic [7:0] sbox [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // queue one block: round keys for the supplier, pt for the source, and
    // the expected ciphertext (model result, or a published vector if given)
    task automatic load_block(input logic [255:0] key, input logic [1:0] kl,
                              input logic [127:0] p, input bit use_ref,
                              input logic [127:0] ref_ct);
        int nk, nr;
        logic [31:0]  w[60];
        logic [31:0]  t;
        logic [127:0] rks[15];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s[16], u[16];
        logic [127:0] res;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            kq.push_back(rks[r]);
        end
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ rks[0][127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) u[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (r < nr) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[r][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        ptq.push_back(p);
        klq.push_back(kl);
        nrq.push_back(nr);
        ctq.push_back(use_ref ? ref_ct : res);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // one clock: drive at negedge, check at negedge+1, advance the model
    task automatic step();
        bit stall, exp_rdy, start, exp_nk;
        @(negedge clk);
        rst   = rst_req;
        stall = (running && since_start >= dstall_at && since_start < dstall_at + dstall_len)
                || ($urandom_range(99) < stall_pct);
        rkey_vld = (kq.size() > 0 || kv_force) && !stall;
        rkey     = (kq.size() > 0) ? kq[0] : rnd128();
        pt_vld   = (ptq.size() > 0) && !($urandom_range(99) < gap_pct);
        pt       = (ptq.size() > 0) ? ptq[0] : rnd128();
        klen_sel = klen_ovr_en ? klen_ovr :
                   (ptq.size() > 0 && !running) ? klq[0] : 2'($urandom_range(3));
        #1;
        exp_rdy = !rst && !running && rkey_vld && (klen_sel != 2'b11);
        start   = exp_rdy && pt_vld;
        exp_nk  = !rst && (start || (running && rkey_vld));
        chk("pt_rdy", pt_rdy, exp_rdy);
        chk("next_rkey", next_rkey, exp_nk);
        if (known) begin
            chk("ct_vld", ct_vld, exp_vld);
            if (!running) chk("ct", ct, exp_ct);
        end
        if (exp_nk && kq.size() > 0) void'(kq.pop_front());
        if (rst) begin
            known = 1; running = 0; exp_vld = 0; exp_ct = '0;
            kq.delete(); ptq.delete(); ctq.delete(); nrq.delete(); klq.delete();
        end else if (start) begin
            void'(ptq.pop_front());
            void'(klq.pop_front());
            keys_left   = nrq.pop_front();
            run_ct      = ctq.pop_front();
            running     = 1;
            since_start = 0;
            exp_vld     = 0;
        end else if (running && rkey_vld) begin
            keys_left--;
            if (keys_left == 0) begin
                running = 0;
                exp_vld = 1;
                exp_ct  = run_ct;
            end
        end
        if (running) since_start++;
    endtask

    // run until all queued blocks finish, then watch two hold cycles
    task automatic drain(input int budget);
        int n = 0;
        while ((running || ptq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", {127'h0, running || ptq.size() > 0}, 128'h0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
        rst_req = 0;
    endtask

    localparam logic [255:0] K_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int n;
        logic [255:0] k;
        logic [1:0]   kl;
        build_sbox();
        rst = 1'b1; pt = '0; pt_vld = 1'b0; rkey = '0; rkey_vld = 1'b0; klen_sel = 2'b00;
        do_reset();
        do_reset();

        // AES-128/192/256 known-answer vectors
        load_block(K_SEQ, 2'b00, PT_C, 1, CT_C1);
        drain(40);
        load_block(K_SEQ, 2'b01, PT_C, 1, CT_C2);
        drain(40);
        load_block(K_SEQ, 2'b10, PT_C, 1, CT_C3);
        drain(40);

        // three-cycle key stall starting at round 4
        dstall_at = 4; dstall_len = 3;
        load_block(K_B, 2'b00, PT_B, 1, CT_B);
        drain(40);
        dstall_at = -1; dstall_len = 0;

        // back-to-back blocks with pt_vld held high
        load_block(K_SEQ, 2'b00, PT_C, 1, CT_C1);
        load_block(K_B, 2'b00, PT_B, 1, CT_B);
        drain(60);

        // invalid key length parks the engine; releasing it starts normally
        do_reset();
        load_block(K_SEQ, 2'b00, PT_C, 1, CT_C1);
        klen_ovr_en = 1; klen_ovr = 2'b11;
        repeat (20) step();
        klen_ovr_en = 0;
        drain(40);

        // synchronous reset at round 5, then a clean run
        load_block(K_SEQ, 2'b00, PT_C, 1, CT_C1);
        n = 0;
        while (!(running && since_start == 5) && n < 40) begin
            step();
            n++;
        end
        chk("reach_round5", {127'h0, running && since_start == 5}, 128'h1);
        do_reset();
        kv_force = 1;
        step();
        step();
        kv_force = 0;
        load_block(K_SEQ, 2'b00, PT_C, 1, CT_C1);
        drain(40);

        // randomized keys, lengths, plaintexts, stalls and source gaps
        stall_pct = 20; gap_pct = 20;
        for (int b = 0; b < 14; b++) begin
            for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
            kl = 2'($urandom_range(2));
            load_block(k, kl, rnd128(), 0, '0);
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
                load_block(k, 2'($urandom_range(2)), rnd128(), 0, '0);
            end
            drain(200);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
